muldiv_sched: RTL and testbench

Sequencing controller between the EX stage and the shared iterative 64-bit divider. It accepts one DIV/DIVU/REM/REMU (and W-variant) request at a time and prepares the operands. It resolves RISC-V special cases (divide-by-zero, signed overflow) and repeated-operand hits without starting the divider. Otherwise it launches the divider and returns one registered result through a valid/ready response port. EX holds its stall while `req_ready` or `resp_valid` is not yet in its favour.

---
 rtl/muldiv_sched.sv | 152 +++++++++++++++
 tb/tb_muldiv_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// Sequencing controller for the shared iterative 64-bit divider: operand prep, RISC-V special
// cases, a single-entry Q/R result cache, and a registered valid/ready response port.
module muldiv_sched (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rem,
   input  logic        req_signed,
   input  logic        req_word,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        div_start,
   output logic [63:0] div_a,
   output logic [63:0] div_b,
   output logic        div_is_signed,
   input  logic        div_ready,
   input  logic [63:0] div_q,
   input  logic [63:0] div_r
);

   typedef enum logic [2:0] {StIdle, StLaunch, StBusy, StDrain, StResp} state_e;

   localparam logic [63:0] AllOnes = '1;
   localparam logic [63:0] MinInt  = 64'h8000_0000_0000_0000;

   function automatic logic [63:0] prep(input logic [63:0] x, input logic sgn, input logic word);
      if (!word) return x;
      return sgn ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
   endfunction

   function automatic logic [63:0] fmt(input logic rem, input logic word,
                                       input logic [63:0] q, input logic [63:0] r);
      logic [63:0] sel;
      sel = rem ? r : q;
      return word ? {{32{sel[31]}}, sel[31:0]} : sel;
   endfunction

   state_e      state_q, state_d;
   logic [63:0] a_q, a_d, b_q, b_d;
   logic        rem_q, rem_d, signed_q, signed_d, word_q, word_d;
   logic [63:0] resp_data_q, resp_data_d;
   logic        div_start_q;
   logic        cache_valid_q, cache_signed_q, cache_we;
   logic [63:0] cache_a_q, cache_b_q, cache_q_q, cache_r_q;
   logic [63:0] a_prep, b_prep;
   logic        cache_hit;

   assign a_prep    = prep(req_a, req_signed, req_word);
   assign b_prep    = prep(req_b, req_signed, req_word);
   // word is not part of the tag: the prepared operands already encode it
   assign cache_hit = cache_valid_q && (cache_a_q == a_prep) && (cache_b_q == b_prep) &&
                      (cache_signed_q == req_signed);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      rem_d       = rem_q;
      signed_d    = signed_q;
      word_d      = word_q;
      resp_data_d = resp_data_q;
      cache_we    = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid && !flush) begin
               a_d      = a_prep;
               b_d      = b_prep;
               rem_d    = req_rem;
               signed_d = req_signed;
               word_d   = req_word;
               state_d  = StResp;
               if (b_prep == '0) begin
                  resp_data_d = fmt(req_rem, req_word, AllOnes, a_prep);
               end else if (!req_word && req_signed && a_prep == MinInt && b_prep == AllOnes) begin
                  resp_data_d = fmt(req_rem, req_word, a_prep, '0);
               end else if (cache_hit) begin
                  resp_data_d = fmt(req_rem, req_word, cache_q_q, cache_r_q);
               end else begin
                  state_d = StLaunch;
               end
            end
         end
         StLaunch: state_d = flush ? StDrain : StBusy;
         StBusy: begin
            if (div_ready) begin
               cache_we = 1'b1;
               if (flush) begin
                  state_d = StIdle;
               end else begin
                  state_d     = StResp;
                  resp_data_d = fmt(rem_q, word_q, div_q, div_r);
               end
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StDrain: if (div_ready) state_d = StIdle;
         StResp:  if (resp_ready || flush) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         a_q            <= '0;
         b_q            <= '0;
         rem_q          <= 1'b0;
         signed_q       <= 1'b0;
         word_q         <= 1'b0;
         resp_data_q    <= '0;
         div_start_q    <= 1'b0;
         cache_valid_q  <= 1'b0;
         cache_signed_q <= 1'b0;
         cache_a_q      <= '0;
         cache_b_q      <= '0;
         cache_q_q      <= '0;
         cache_r_q      <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rem_q       <= rem_d;
         signed_q    <= signed_d;
         word_q      <= word_d;
         resp_data_q <= resp_data_d;
         div_start_q <= (state_d == StLaunch);
         if (cache_we) begin
            cache_valid_q  <= 1'b1;
            cache_signed_q <= signed_q;
            cache_a_q      <= a_q;
            cache_b_q      <= b_q;
            cache_q_q      <= div_q;
            cache_r_q      <= div_r;
         end
      end
   end

   assign req_ready     = (state_q == StIdle);
   assign resp_valid    = (state_q == StResp);
   assign resp_data     = resp_data_q;
   assign div_start     = div_start_q;
   assign div_a         = a_q;
   assign div_b         = b_q;
   assign div_is_signed = signed_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed scenarios plus randomized requests checked
// against an arithmetic RISC-V division model, an ideal divider and a last-launch cache model.
module tb_muldiv_sched;

   localparam logic [63:0] AllOnes = '1;
   localparam logic [63:0] MinInt  = 64'h8000_0000_0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_rem, req_signed, req_word;
   logic [63:0] req_a, req_b;
   logic        flush;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_data;
   logic        div_start, div_is_signed, div_ready;
   logic [63:0] div_a, div_b, div_q, div_r;

   int errors = 0;
   int checks = 0;

   // model of which operand set the block should remember
   logic        m_valid = 1'b0;
   logic        m_sgn;
   logic [63:0] m_a, m_b;

   muldiv_sched dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rem       (req_rem),
      .req_signed    (req_signed),
      .req_word      (req_word),
      .req_a         (req_a),
      .req_b         (req_b),
      .flush         (flush),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .div_start     (div_start),
      .div_a         (div_a),
      .div_b         (div_b),
      .div_is_signed (div_is_signed),
      .div_ready     (div_ready),
      .div_q         (div_q),
      .div_r         (div_r)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] prep(input logic [63:0] x, input logic sgn, input logic word);
      logic [31:0] lo;
      lo = x[31:0];
      if (!word) return x;
      if (sgn) return {{32{lo[31]}}, lo};
      return {32'h0, lo};
   endfunction

   // RISC-V M-extension result, computed at the architectural width
   function automatic logic [63:0] ref_rd(input logic [63:0] a, input logic [63:0] b,
                                          input logic rem, input logic sgn, input logic word);
      logic [31:0] a32, b32, q32, r32, s32;
      logic [63:0] q64, r64;
      a32 = a[31:0];
      b32 = b[31:0];
      if (word) begin
         if (b32 == 32'h0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32;
         end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'h0;
         end else if (sgn) begin
            q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
         end else begin
            q32 = a32 / b32; r32 = a32 % b32;
         end
         s32 = rem ? r32 : q32;
         return {{32{s32[31]}}, s32};
      end
      if (b == 64'h0) begin
         q64 = AllOnes; r64 = a;
      end else if (sgn && a == MinInt && b == AllOnes) begin
         q64 = a; r64 = 64'h0;
      end else if (sgn) begin
         q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
      end else begin
         q64 = a / b; r64 = a % b;
      end
      return rem ? r64 : q64;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 6))
         0: return 64'h0;
         1: return AllOnes;
         2: return MinInt;
         3: return 64'(($urandom_range(0, 40)));
         4: return 64'h0000_0000_8000_0000;
         5: return {32'hFFFF_FFFF, $urandom()};
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // one full request/response transaction with an ideal divider of latency k
   task automatic do_req(input logic [63:0] a, input logic [63:0] b, input logic rem,
                         input logic sgn, input logic word, input int k, input int stall);
      logic [63:0] pa, pb, exp_rd, dq, dr;
      logic        launch;
      pa     = prep(a, sgn, word);
      pb     = prep(b, sgn, word);
      exp_rd = ref_rd(a, b, rem, sgn, word);
      launch = (pb != 64'h0) && !(!word && sgn && pa == MinInt && pb == AllOnes) &&
               !(m_valid && m_a == pa && m_b == pb && m_sgn == sgn);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL req_ready_before: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_a = a; req_b = b; req_rem = rem; req_signed = sgn; req_word = word;
      tick();
      req_valid = 1'b0; req_a = {$urandom(), $urandom()}; req_b = {$urandom(), $urandom()};
      checks++;
      if (div_start !== launch) begin
         errors++; $display("FAIL div_start: got %b want %b", div_start, launch);
      end
      if (launch) begin
         checks++;
         if (div_a !== pa || div_b !== pb || div_is_signed !== sgn) begin
            errors++;
            $display("FAIL div_operands: got a=%h b=%h s=%b want a=%h b=%h s=%b",
                     div_a, div_b, div_is_signed, pa, pb, sgn);
         end
         if (sgn) begin
            dq = $signed(pa) / $signed(pb); dr = $signed(pa) % $signed(pb);
         end else begin
            dq = pa / pb; dr = pa % pb;
         end
         repeat (k) begin
            tick();
            checks++;
            if (div_start !== 1'b0 || resp_valid !== 1'b0 || div_a !== pa || div_b !== pb) begin
               errors++;
               $display("FAIL busy_wait: got start=%b valid=%b a=%h b=%h want 0 0 %h %h",
                        div_start, resp_valid, div_a, div_b, pa, pb);
            end
         end
         div_ready = 1'b1; div_q = dq; div_r = dr;
         tick();
         div_ready = 1'b0; div_q = {$urandom(), $urandom()}; div_r = {$urandom(), $urandom()};
         m_valid = 1'b1; m_a = pa; m_b = pb; m_sgn = sgn;
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_rd) begin
         errors++;
         $display("FAIL resp: got valid=%b data=%h want 1 %h", resp_valid, resp_data, exp_rd);
      end
      repeat (stall) begin
         tick();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== exp_rd) begin
            errors++;
            $display("FAIL resp_hold: got valid=%b data=%h want 1 %h",
                     resp_valid, resp_data, exp_rd);
         end
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL consume: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'h0 ||
          div_start !== 1'b0 || div_a !== 64'h0 || div_b !== 64'h0 || div_is_signed !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b d=%h st=%b a=%h b=%h s=%b want 1 0 0 0 0 0 0",
                  req_ready, resp_valid, resp_data, div_start, div_a, div_b, div_is_signed);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      do_req(-64'sd7, 64'd2, 1'b0, 1'b1, 1'b0, 5, 0);                      // DIV, launches
      do_req(-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 1, 0);                      // REM, cache hit
      do_req(64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, 1, 0);                     // DIVU by zero
      do_req(64'h1234, 64'h0, 1'b1, 1'b0, 1'b0, 1, 0);                     // REMU by zero
      do_req(MinInt, AllOnes, 1'b0, 1'b1, 1'b0, 1, 0);                     // overflow DIV
      do_req(MinInt, AllOnes, 1'b1, 1'b1, 1'b0, 1, 0);                     // overflow REM
      do_req(64'hFFFF_FFFF_0000_0010, 64'h2, 1'b0, 1'b0, 1'b1, 3, 0);      // DIVUW
      do_req(64'h0000_0000_FFFF_FFF9, 64'h0, 1'b1, 1'b1, 1'b1, 1, 0);      // REMW by zero
      do_req(64'h0000_0000_8000_0000, AllOnes, 1'b0, 1'b1, 1'b1, 2, 0);    // DIVW overflow
   endtask

   task automatic test_flush();
      req_valid = 1'b1; req_a = 64'd1000; req_b = 64'd13; req_rem = 1'b0;
      req_signed = 1'b0; req_word = 1'b0;
      tick();
      req_valid = 1'b0;
      checks++;
      if (div_start !== 1'b1) begin
         errors++; $display("FAIL flush_launch: got %b want 1", div_start);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (3) begin
         checks++;
         if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_wait: got ready=%b valid=%b want 0 0", req_ready, resp_valid);
         end
         tick();
      end
      div_ready = 1'b1; div_q = 64'd76; div_r = 64'd12;
      tick();
      div_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_exit: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
      end
      // drained result never reaches the cache, so the same request launches again
      do_req(64'd1000, 64'd13, 1'b0, 1'b0, 1'b0, 2, 0);
      // a request alongside flush is ignored
      req_valid = 1'b1; flush = 1'b1; req_a = 64'd5; req_b = 64'd0;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_start !== 1'b0) begin
         errors++;
         $display("FAIL flush_accept: got ready=%b valid=%b start=%b want 1 0 0",
                  req_ready, resp_valid, div_start);
      end
   endtask

   task automatic test_stall();
      do_req(64'd99, 64'd10, 1'b1, 1'b0, 1'b0, 2, 4);
      do_req(64'd99, 64'd0, 1'b0, 1'b1, 1'b0, 1, 4);
   endtask

   task automatic test_reset_busy();
      do_req(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1, 0);
      req_valid = 1'b1; req_a = 64'd200; req_b = 64'd9; req_rem = 1'b0;
      req_signed = 1'b1; req_word = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'h0 ||
          div_start !== 1'b0 || div_a !== 64'h0 || div_b !== 64'h0 || div_is_signed !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got rdy=%b v=%b d=%h st=%b a=%h b=%h s=%b want 1 0 0 0 0 0 0",
                  req_ready, resp_valid, resp_data, div_start, div_a, div_b, div_is_signed);
      end
      m_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      div_ready = 1'b1; div_q = 64'd22; div_r = 64'd2;
      tick();
      div_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL late_div_ready: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
      end
      do_req(64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 1, 0);
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      logic        rem, sgn, word;
      a = 64'd1; b = 64'd1; sgn = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            a = pick(); b = pick(); sgn = 1'($urandom_range(0, 1));
         end
         rem  = 1'($urandom_range(0, 1));
         word = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            div_ready = 1'b1; div_q = {$urandom(), $urandom()}; div_r = {$urandom(), $urandom()};
            tick();
            div_ready = 1'b0;
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_start !== 1'b0) begin
               errors++;
               $display("FAIL stray_div_ready: got ready=%b valid=%b start=%b want 1 0 0",
                        req_ready, resp_valid, div_start);
            end
         end
         do_req(a, b, rem, sgn, word, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_rem = 1'b0; req_signed = 1'b0; req_word = 1'b0;
      req_a = '0; req_b = '0; flush = 1'b0; resp_ready = 1'b0;
      div_ready = 1'b0; div_q = '0; div_r = '0;
      test_reset();
      test_directed();
      test_flush();
      test_stall();
      test_reset_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
